// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared definitions for the multi-cycle ALU.
// Contents: op-code enum alu_op_t, control FSM state enum state_t,
// and is_div_op(), which tells whether an op uses the iterative divider.
package alu_mc_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLT  = 4'd2,
    OP_SLTU = 4'd3,
    OP_AND  = 4'd4,
    OP_NOR  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_LUI  = 4'd11,
    OP_DIV  = 4'd12,
    OP_DIVU = 4'd13,
    OP_REM  = 4'd14,
    OP_REMU = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_HOLD
  } state_t;

  function automatic logic is_div_op(input alu_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle of the multi-cycle ALU.
// Request side : in_valid, in_ready, in_op, in_src1, in_src2.
// Response side: out_valid, out_ready, out_result, out_overflow, out_div_zero.
// master = issuing stage, slave = the ALU.
interface alu_mc_if
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  alu_op_t          in_op;
  logic [WIDTH-1:0] in_src1;
  logic [WIDTH-1:0] in_src2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_overflow;
  logic             out_div_zero;

  modport master (
    output in_valid, in_op, in_src1, in_src2, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_div_zero
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_div_zero
  );

endinterface

// File: rtl/alu_mc_div.sv
// alu_mc_div: iterative radix-2 restoring divider, one quotient bit per cycle.
// Ports: clk, rst (synchronous, active-high); start loads dividend/divisor
// and signed_op; done is high in the cycle of the final iteration, and during
// that cycle quotient/remainder/div_zero show the sign-corrected result of it.
module alu_mc_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             running;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] quo;      // dividend shifts out of the top, quotient bits in at the bottom
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [WIDTH-1:0] dsr;      // divisor magnitude
  logic             neg_quo;
  logic             neg_rem;
  logic             zero_dsr;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] rem_nxt;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dsr};
    quo_nxt = {quo[WIDTH-2:0], 1'b0};
    rem_nxt = shifted[WIDTH-1:0];
    // Borrow clear: divisor fits, keep the difference and set the quotient bit.
    if (!trial[WIDTH]) begin
      quo_nxt[0] = 1'b1;
      rem_nxt    = trial[WIDTH-1:0];
    end
  end

  // NOTE: registered state is written only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      count   <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= CNT_W'(WIDTH - 1);
    end else if (running) begin
      if (count == '0) running <= 1'b0;
      else             count   <= count - CNT_W'(1);
    end
  end

  // NOTE: datapath registers have no reset; start always loads them before they are read.
  always_ff @(posedge clk) begin
    if (start) begin
      quo      <= (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
      dsr      <= (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
      rem      <= '0;
      neg_quo  <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_rem  <= signed_op && dividend[WIDTH-1];
      zero_dsr <= (divisor == '0);
    end else if (running) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
    end
  end

  // With a zero divisor every step "fits", so rem_nxt ends as |dividend| and
  // re-signing it gives back the original dividend; only the quotient is forced.
  assign done      = running && (count == '0);
  assign quotient  = zero_dsr ? '1 : (neg_quo ? -quo_nxt : quo_nxt);
  assign remainder = neg_rem ? -rem_nxt : rem_nxt;
  assign div_zero  = zero_dsr;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
// Ports: clk, rst (synchronous, active-high), bus (alu_mc_if.slave).
// Single-cycle ops are computed combinationally from the request and
// registered on the accept edge; DIV/DIVU/REM/REMU run through alu_mc_div.
// out_valid is the HOLD state; results and flags are held until consumed.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);

  logic [WIDTH-1:0]   src1, src2;
  logic [WIDTH-1:0]   sum, diff;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;

  state_t             state, state_nxt;
  logic               accept;
  logic               load_alu, load_div, div_start;
  logic               div_done, div_zero, rem_sel;
  logic [WIDTH-1:0]   div_quo, div_rem;

  logic [WIDTH-1:0]   result;
  logic               overflow, zero_flag;

  assign src1  = bus.in_src1;
  assign src2  = bus.in_src2;
  assign sum   = src1 + src2;
  assign diff  = src1 - src2;
  assign shamt = src1[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.in_op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src1 < src2)};
      OP_AND:  alu_res = src1 & src2;
      OP_NOR:  alu_res = ~(src1 | src2);
      OP_OR:   alu_res = src1 | src2;
      OP_XOR:  alu_res = src1 ^ src2;
      OP_SLL:  alu_res = src2 << shamt;
      OP_SRL:  alu_res = src2 >> shamt;
      OP_SRA:  alu_res = $signed(src2) >>> shamt;
      OP_LUI:  alu_res = {src2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: alu_res = '0;  // divide ops take their result from the divider
    endcase
  end

  // HOLD with out_ready means the held result leaves on this edge, so a new op may enter.
  assign bus.in_ready = (state == ST_IDLE) || ((state == ST_HOLD) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_nxt = state;
    load_alu  = 1'b0;
    load_div  = 1'b0;
    div_start = 1'b0;
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          if (is_div_op(bus.in_op)) begin
            state_nxt = ST_BUSY;
            div_start = 1'b1;
          end else begin
            state_nxt = ST_HOLD;
            load_alu  = 1'b1;
          end
        end else if ((state == ST_IDLE) || bus.out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (div_done) begin
          state_nxt = ST_HOLD;
          load_div  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (div_start) rem_sel <= bus.in_op inside {OP_REM, OP_REMU};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      overflow  <= 1'b0;
      zero_flag <= 1'b0;
    end else if (load_alu) begin
      result    <= alu_res;
      overflow  <= alu_ovf;
      zero_flag <= 1'b0;
    end else if (load_div) begin
      result    <= rem_sel ? div_rem : div_quo;
      overflow  <= 1'b0;
      zero_flag <= div_zero;
    end
  end

  alu_mc_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (bus.in_op inside {OP_DIV, OP_REM}),
    .dividend  (src1),
    .divisor   (src2),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem),
    .div_zero  (div_zero)
  );

  assign bus.out_valid    = (state == ST_HOLD);
  assign bus.out_result   = result;
  assign bus.out_overflow = overflow;
  assign bus.out_div_zero = zero_flag;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (WIDTH=32).
// A negedge monitor keeps a queue of expected responses computed with plain
// 64-bit arithmetic and checks out_valid, in_ready and the response fields on
// every cycle; directed cases pin literal results, latencies and flow control.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int WIDTH = 32;

  bit   clk = 1'b0;
  logic rst = 1'b1;

  alu_mc_if #(.WIDTH(WIDTH)) bus ();

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             dz;
    int               due;
  } exp_t;

  // Reference behaviour from the arithmetic definition of each op.
  function automatic exp_t model(input alu_op_t op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t            e;
    longint          sa, sb, t;
    longint unsigned ua, ub;
    int              sh;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    ua    = {32'd0, a};
    ub    = {32'd0, b};
    sh    = int'(a[4:0]);
    e.res = '0;
    e.ovf = 1'b0;
    e.dz  = 1'b0;
    e.due = 0;
    case (op)
      OP_ADD:  begin t = sa + sb; e.res = t[31:0]; e.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      OP_SUB:  begin t = sa - sb; e.res = t[31:0]; e.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      OP_SLT:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: e.res = (ua < ub) ? 32'd1 : 32'd0;
      OP_AND:  e.res = a & b;
      OP_NOR:  e.res = ~(a | b);
      OP_OR:   e.res = a | b;
      OP_XOR:  e.res = a ^ b;
      OP_SLL:  begin t = longint'(ub * (64'd1 << sh)); e.res = t[31:0]; end
      OP_SRL:  begin t = longint'(ub / (64'd1 << sh)); e.res = t[31:0]; end
      OP_SRA:  begin t = sb >>> sh; e.res = t[31:0]; end
      OP_LUI:  e.res = b * 32'h0001_0000;
      OP_DIV:  if (b == 0) begin e.res = '1; e.dz = 1'b1; end else begin t = sa / sb; e.res = t[31:0]; end
      OP_REM:  if (b == 0) begin e.res = a;  e.dz = 1'b1; end else begin t = sa % sb; e.res = t[31:0]; end
      OP_DIVU: if (b == 0) begin e.res = '1; e.dz = 1'b1; end else begin t = longint'(ua / ub); e.res = t[31:0]; end
      OP_REMU: if (b == 0) begin e.res = a;  e.dz = 1'b1; end else begin t = longint'(ua % ub); e.res = t[31:0]; end
      default: e.res = '0;
    endcase
    return e;
  endfunction

  // ---------------------------------------------------------------- monitor
  int   cyc = 0;
  exp_t pend[$];
  bit   armed = 1'b0;
  bit   prev_rst = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic exp_v;
    exp_t e;
    exp_v = (pend.size() > 0) && (cyc >= pend[0].due);
    if (armed) begin
      check("out_valid", bus.out_valid, exp_v);
      check("in_ready", bus.in_ready, (pend.size() == 0) || (exp_v && bus.out_ready));
      if (exp_v && bus.out_valid) begin
        check("out_result", bus.out_result, pend[0].res);
        check("out_overflow", bus.out_overflow, pend[0].ovf);
        check("out_div_zero", bus.out_div_zero, pend[0].dz);
      end
      if (prev_rst) begin
        check("reset out_result", bus.out_result, 0);
        check("reset out_overflow", bus.out_overflow, 0);
        check("reset out_div_zero", bus.out_div_zero, 0);
      end
    end
    if (rst) begin
      pend.delete();
      armed = 1'b1;
    end else if (armed) begin
      if (exp_v && bus.out_ready) void'(pend.pop_front());
      if (bus.in_valid && bus.in_ready) begin
        e     = model(bus.in_op, bus.in_src1, bus.in_src2);
        e.due = cyc + 1 + (is_div_op(bus.in_op) ? WIDTH : 0);
        pend.push_back(e);
      end
    end
    prev_rst = rst;
  end

  // ---------------------------------------------------------------- drivers
  task automatic issue(input alu_op_t op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int   waited;
    logic acc;
    waited       = 0;
    acc          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_src1  = a;
    bus.in_src2  = b;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    bus.in_valid = 1'b0;
    check("accept within bound", acc, 1);
  endtask

  task automatic directed(input string name, input alu_op_t op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] er, input logic eo, input logic ed,
                          input int elat);
    int lat;
    int ready_in_busy;
    bus.out_ready = 1'b1;
    issue(op, a, b);
    lat           = 1;
    ready_in_busy = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) ready_in_busy++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, " latency"}, lat, elat);
    check({name, " in_ready while busy"}, ready_in_busy, 0);
    check({name, " result"}, bus.out_result, er);
    check({name, " overflow"}, bus.out_overflow, eo);
    check({name, " div_zero"}, bus.out_div_zero, ed);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      6:       return -32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached with %0d checks", n_checks);
    $fatal(1);
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    alu_op_t op;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_ADD;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", bus.in_ready, 1);
    check("post-reset out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;

    directed("ADD ovf",  OP_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1, 0, 1);
    directed("SUB ovf",  OP_SUB,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1, 0, 1);
    directed("SLT",      OP_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         0, 0, 1);
    directed("SLTU",     OP_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         0, 0, 1);
    directed("SRA",      OP_SRA,  32'h4,         32'h8000_0000, 32'hF800_0000, 0, 0, 1);
    directed("LUI",      OP_LUI,  32'h0,         32'h1234,      32'h1234_0000, 0, 0, 1);
    directed("DIV",      OP_DIV,  -32'sd7,       32'd2,         32'hFFFF_FFFD, 0, 0, WIDTH + 1);
    directed("REM",      OP_REM,  -32'sd7,       32'd2,         32'hFFFF_FFFF, 0, 0, WIDTH + 1);
    directed("DIVU",     OP_DIVU, 32'hFFFF_FFFE, 32'd7,         32'h2492_4924, 0, 0, WIDTH + 1);
    directed("DIVU /0",  OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 0, 1, WIDTH + 1);
    directed("REM /0",   OP_REM,  32'd5,         32'd0,         32'h5,         0, 1, WIDTH + 1);
    directed("DIV MIN",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, WIDTH + 1);

    // Held result with back-pressure; the pending request must not be accepted.
    bus.out_ready = 1'b0;
    issue(OP_ADD, 32'd10, 32'd20);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_ADD;
    bus.in_src1  = 32'd100;
    bus.in_src2  = 32'd1;
    repeat (5) begin
      @(negedge clk);
      check("hold out_valid", bus.out_valid, 1);
      check("hold out_result", bus.out_result, 32'd30);
      check("hold in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
    end

    // Four back-to-back ADDs, one result per cycle.
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = OP_ADD;
      bus.in_src1  = 32'(i);
      bus.in_src2  = 32'd1000;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("b2b out_valid", bus.out_valid, 1);
      check("b2b out_result", bus.out_result, 32'(1000 + i));
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("b2b drained", bus.out_valid, 0);
    @(posedge clk);
    #1;

    // Reset in the 10th BUSY cycle discards the divide.
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid-busy reset out_valid", bus.out_valid, 0);
    check("mid-busy reset in_ready", bus.in_ready, 1);
    check("mid-busy reset out_result", bus.out_result, 0);
    @(posedge clk);
    #1;
    directed("ADD after reset", OP_ADD, 32'd2, 32'd3, 32'd5, 0, 0, 1);

    // Randomized traffic with random back-pressure, checked by the monitor.
    for (int k = 0; k < 3000; k++) begin
      op = alu_op_t'(4'($urandom_range(0, 15)));
      if (is_div_op(op) && ($urandom_range(0, 2) != 0)) op = alu_op_t'(4'($urandom_range(0, 11)));
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_op     = op;
      bus.in_src1   = rand_operand();
      bus.in_src2   = rand_operand();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (WIDTH + 5) @(posedge clk);
    #1;
    @(negedge clk);
    check("final idle out_valid", bus.out_valid, 0);
    check("final queue empty", pend.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the multi-cycle CPU execute stage. It replaces the purely combinational ALU and its single-cycle divider with a valid/ready operation unit. Single-cycle ops return after 1 cycle. Signed and unsigned divide and remainder use an iterative radix-2 restoring divider taking WIDTH cycles. The control FSM issues one op and stalls on `in_ready`/`out_valid`.

## Interface
- `WIDTH`, 32: datapath width; even, ≥8.
- `SHAMT_W`, $clog2(WIDTH): shift-amount width.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept a request this cycle.
- `in_op`  in  4  encoded op (package `alu_mc_pkg`).
- `in_src1`  in  WIDTH  operand 1; shifts use `in_src1[SHAMT_W-1:0]` as amount.
- `in_src2`  in  WIDTH  operand 2; shifted value for shifts; immediate for LUI.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `out_result`  out  WIDTH  result.
- `out_overflow`  out  1  signed overflow (ADD/SUB only).
- `out_div_zero`  out  1  divisor was zero (DIV/DIVU/REM/REMU only).

## Operation
- Op codes:
  - ADD=0, SUB=1, SLT=2, SLTU=3, AND=4, NOR=5, OR=6, XOR=7
  - SLL=8, SRL=9, SRA=10, LUI=11, DIV=12, DIVU=13, REM=14, REMU=15
- Arithmetic and logic are modulo 2^WIDTH.
  - SLT/SLTU yield 0 or 1, zero-extended.
  - LUI = {src2[WIDTH/2-1:0], WIDTH/2 zeros}.
  - SRA replicates src2 MSB.
- Overflow:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from src1.
  - Otherwise 0. The result is written regardless.
- Divide:
  - Operate on magnitudes; DIV/REM negate src1/src2 if negative.
  - Quotient sign = src1 sign XOR src2 sign. Remainder sign = src1 sign.
  - Divisor 0: quotient = all ones; remainder = src1; `out_div_zero`=1; full WIDTH-cycle latency is still taken.
  - DIV of MIN by −1: quotient = MIN, remainder = 0, `out_overflow`=0.
- FSM states: IDLE, BUSY, HOLD.
  - IDLE, accept non-div op → HOLD.
  - IDLE, accept div op → BUSY, iteration counter = WIDTH−1.
  - BUSY: one quotient bit per cycle; counter 0 → HOLD with signs fixed.
  - HOLD and `out_ready`: accept new op if `in_valid`, transitioning as from IDLE; else → IDLE.
- `in_ready` = IDLE, or (HOLD and `out_ready`). A request is accepted when `in_valid && in_ready`; operands are captured on that edge.
- Results and flags are registered and held stable while `out_valid && !out_ready`.

## Timing
- Reset:
  - State IDLE, `out_valid`=0, `out_result`=0, both flags 0.
  - `in_ready`=1 the first cycle after reset deasserts.
- Non-div latency: accept at edge N → `out_valid`=1 from edge N+1.
- Div latency: accept at edge N → `out_valid`=1 from edge N+WIDTH+1.
  - `in_ready`=0 during BUSY.
- Back-to-back:
  - Result consumed and new op accepted on the same edge, when in HOLD with `out_ready` and `in_valid`.
  - Non-div ops sustain 1 op/cycle.
- `out_valid` stays high until the `out_valid && out_ready` edge.
  - It drops the next cycle unless a new non-div result is produced.
- Reset mid-BUSY or mid-HOLD: the op is discarded with no result; all outputs return to reset values next cycle.
- `in_op`/`in_src*` are ignored when not accepted.

## Structure
- `alu_mc_pkg`: op-code localparams/typedef `alu_op_t`, state enum, helper `is_div_op`.
- Sub-module `alu_mc_div`:
  - Restoring iterative divider with ports `start`/`signed_op`/`done`.
  - Holds the shift register, partial remainder and counter.
- Top holds the combinational datapath, FSM and output registers.

## Test plan
- ADD 0x7FFFFFFF + 1 (WIDTH=32) → result 0x80000000, overflow=1, `out_valid` 1 cycle after accept.
  - SUB 0x80000000 − 1 → 0x7FFFFFFF, overflow=1.
- SLT src1=0xFFFFFFFF, src2=1 → 1. SLTU on the same operands → 0.
  - SRA src1=4, src2=0x80000000 → 0xF8000000. LUI src2=0x1234 → 0x12340000.
- DIV −7/2 → quotient 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 0xFFFFFFFE/7 → 0x24924924.
  - `out_valid` exactly 33 cycles after accept, `in_ready`=0 throughout BUSY.
- DIVU 5/0 → 0xFFFFFFFF, div_zero=1; REM 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000, overflow=0.
- `out_ready` held low 5 cycles in HOLD → result stable, no new accept.
  - Then 4 back-to-back ADDs with `out_ready`=1 → 4 results on 4 consecutive cycles.
- Assert `rst` at BUSY cycle 10 → next cycle IDLE, `out_valid`=0, `in_ready`=1.
  - A following ADD 2+3 → 5.
